// File: rtl/tdm_demux_1x8.sv
// Receive end of an 8-channel TDM link: locks to SYNC and republishes each good frame on y_o.
// Define TDM_DEMUX_CLR_ON_LOSS_EN to clear y_o whenever lock is lost.
module tdm_demux_1x8 #(
   parameter int unsigned ACQ_FRAMES = 2,
   parameter int unsigned MISS_LIMIT = 2
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       en_i,
   input  logic       din_i,
   input  logic       sync_i,
   output logic [7:0] y_o,
   output logic       frame_valid_o,
   output logic       locked_o,
   output logic       sync_err_o,
   output logic [2:0] slot_o
);

   typedef enum logic [1:0] {StHunt, StAcquire, StLocked} state_e;

   state_e     state_q, state_d;
   logic [2:0] slot_q, slot_d;
   logic [6:0] frame_q, frame_d;
   logic [3:0] good_q, good_d;
   logic [3:0] miss_q, miss_d;
   logic [7:0] y_q, y_d;
   logic       fv_q, fv_d;
   logic       err_q, err_d;
   logic [4:0] good_inc;
   logic [4:0] miss_inc;

   assign good_inc = {1'b0, good_q} + 5'd1;
   assign miss_inc = {1'b0, miss_q} + 5'd1;

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      frame_d = frame_q;
      good_d  = good_q;
      miss_d  = miss_q;
      y_d     = y_q;
      fv_d    = 1'b0;
      err_d   = 1'b0;
      if (en_i) begin
         if (state_q == StHunt) begin
            if (sync_i) begin
               frame_d = {6'b0, din_i};
               slot_d  = 3'd1;
               good_d  = 4'd0;
               miss_d  = 4'd0;
               state_d = StAcquire;
            end
         end else if (sync_i && slot_q != 3'd0) begin
            // Early marker: restart the frame on this bit.
            err_d   = 1'b1;
            frame_d = {6'b0, din_i};
            slot_d  = 3'd1;
            good_d  = 4'd0;
            miss_d  = 4'd0;
            state_d = StAcquire;
         end else if (slot_q == 3'd0 && !sync_i) begin
            if (state_q == StLocked && miss_inc < 5'(MISS_LIMIT)) begin
               // Flywheel through a missing marker.
               miss_d     = miss_inc[3:0];
               frame_d[0] = din_i;
               slot_d     = 3'd1;
            end else begin
               err_d   = 1'b1;
               good_d  = 4'd0;
               miss_d  = 4'd0;
               state_d = StHunt;
            end
         end else if (slot_q == 3'd7) begin
            slot_d = 3'd0;
            if (state_q == StLocked || good_inc >= 5'(ACQ_FRAMES)) begin
               state_d = StLocked;
               good_d  = 4'd0;
               y_d     = {din_i, frame_q};
               fv_d    = 1'b1;
            end else begin
               good_d = good_inc[3:0];
            end
         end else begin
            if (slot_q == 3'd0) begin
               miss_d = 4'd0;
            end
            frame_d[slot_q] = din_i;
            slot_d          = slot_q + 3'd1;
         end
      end
`ifdef TDM_DEMUX_CLR_ON_LOSS_EN
      if (state_q == StLocked && state_d != StLocked) begin
         y_d = 8'h00;
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StHunt;
         slot_q  <= 3'd0;
         frame_q <= 7'd0;
         good_q  <= 4'd0;
         miss_q  <= 4'd0;
         y_q     <= 8'h00;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         frame_q <= frame_d;
         good_q  <= good_d;
         miss_q  <= miss_d;
         y_q     <= y_d;
         fv_q    <= fv_d;
         err_q   <= err_d;
      end
   end

   assign y_o           = y_q;
   assign frame_valid_o = fv_q;
   assign locked_o      = (state_q == StLocked);
   assign sync_err_o    = err_q;
   assign slot_o        = slot_q;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Self-checking bench for tdm_demux_1x8: frame-level reference model plus directed literal checks.
module tb_tdm_demux_1x8;

   localparam int unsigned Acq  = 2;
   localparam int unsigned Miss = 2;
`ifdef TDM_DEMUX_CLR_ON_LOSS_EN
   localparam bit Clr = 1'b1;
`else
   localparam bit Clr = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       din = 1'b0;
   logic       sync = 1'b0;
   logic [7:0] y;
   logic       fv;
   logic       locked;
   logic       err;
   logic [2:0] slot;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   tdm_demux_1x8 #(
      .ACQ_FRAMES(Acq),
      .MISS_LIMIT(Miss)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .en_i         (en),
      .din_i        (din),
      .sync_i       (sync),
      .y_o          (y),
      .frame_valid_o(fv),
      .locked_o     (locked),
      .sync_err_o   (err),
      .slot_o       (slot)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode 0 hunt, 1 acquire, 2 locked; pos = slot expected next.
   int m_mode = 0, m_pos = 0, m_good = 0, m_miss = 0, m_y = 0, m_fv = 0, m_err = 0;
   int m_bits[8];

   task automatic m_start();
      foreach (m_bits[k]) m_bits[k] = 0;
      m_bits[0] = int'(din);
      m_pos = 1; m_good = 0; m_miss = 0; m_mode = 1;
   endtask

   task automatic m_lose();
      if (m_mode == 2 && Clr) m_y = 0;
   endtask

   function automatic int m_word();
      int w = 0;
      for (int k = 0; k < 8; k++) w += m_bits[k] * (1 << k);
      return w;
   endfunction

   always @(posedge clk) begin
      m_fv = 0;
      m_err = 0;
      if (!rst_n) begin
         m_mode = 0; m_pos = 0; m_good = 0; m_miss = 0; m_y = 0;
         foreach (m_bits[k]) m_bits[k] = 0;
      end else if (en) begin
         if (m_mode == 0) begin
            if (sync) m_start();
         end else if (sync && m_pos != 0) begin
            m_err = 1; m_lose(); m_start();
         end else if (m_pos == 0 && !sync && (m_mode == 1 || m_miss + 1 >= int'(Miss))) begin
            m_err = 1; m_lose(); m_mode = 0; m_miss = 0; m_good = 0;
         end else begin
            if (m_pos == 0) m_miss = sync ? 0 : m_miss + 1;
            m_bits[m_pos] = int'(din);
            m_pos = (m_pos + 1) % 8;
            if (m_pos == 0) begin
               if (m_mode == 1) begin
                  m_good++;
                  if (m_good >= int'(Acq)) m_mode = 2;
               end
               if (m_mode == 2) begin
                  m_y = m_word(); m_fv = 1;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_y", y, m_y);
         check("model_fv", fv, m_fv);
         check("model_err", err, m_err);
         check("model_locked", locked, m_mode == 2);
         check("model_slot", slot, m_pos);
         check("fv_err_exclusive", fv & err, 0);
      end
   end

   task automatic tick(input logic e, input logic d, input logic s);
      @(negedge clk);
      en = e; din = d; sync = s;
   endtask

   task automatic strobe(input logic d, input logic s, input int gap);
      // Idle cycles carry junk on din/sync that must be ignored.
      repeat (gap) tick(1'b0, 1'b1, 1'b1);
      tick(1'b1, d, s);
   endtask

   task automatic send(input logic [7:0] w, input bit s0, input int gap);
      for (int k = 0; k < 8; k++) strobe(w[k], s0 && k == 0, gap);
   endtask

   task automatic after();
      @(posedge clk);
      #1;
   endtask

   task automatic set_rst(input logic v);
      @(negedge clk);
      rst_n = v; en = 1'b0; sync = 1'b0;
   endtask

   initial begin
      logic [7:0] w;
      repeat (2) tick(1'b0, 1'b0, 1'b0);
      after();
      chk_en = 1'b1;
      check("rst_y", y, 8'h00);
      check("rst_fv", fv, 0);
      check("rst_locked", locked, 0);
      check("rst_slot", slot, 0);
      check("rst_err", err, 0);
      set_rst(1'b1);

      strobe(1'b1, 1'b0, 0);
      after();
      check("hunt_drop_slot", slot, 0);

      send(8'hA5, 1'b1, 0);
      after();
      check("acq1_no_fv", fv, 0);
      check("acq1_not_locked", locked, 0);
      send(8'h3C, 1'b1, 0);
      after();
      check("lock_y", y, 8'h3C);
      check("lock_fv", fv, 1);
      check("lock_locked", locked, 1);
      send(8'hF0, 1'b1, 0);
      after();
      check("f0_y", y, 8'hF0);

      w = 8'h81;
      strobe(w[0], 1'b1, 2);
      after();
      check("sparse_slot1", slot, 1);
      tick(1'b0, 1'b0, 1'b1);
      after();
      check("sparse_slot_hold", slot, 1);
      for (int k = 1; k < 8; k++) strobe(w[k], 1'b0, 2);
      after();
      check("sparse_y", y, 8'h81);
      check("sparse_fv", fv, 1);

      send(8'h55, 1'b0, 0);
      after();
      check("fly_y", y, 8'h55);
      check("fly_fv", fv, 1);
      check("fly_locked", locked, 1);
      strobe(1'b1, 1'b0, 0);
      after();
      check("miss_err", err, 1);
      check("miss_locked", locked, 0);
      check("miss_slot", slot, 0);
      check("miss_y", y, Clr ? 8'h00 : 8'h55);
      check("miss_fv", fv, 0);
      for (int k = 1; k < 8; k++) strobe(k[0], 1'b0, 0);
      after();
      check("hunt_ignore_slot", slot, 0);

      send(8'h11, 1'b1, 0);
      send(8'h22, 1'b1, 0);
      after();
      check("relock_y", y, 8'h22);
      w = 8'h2D;
      for (int k = 0; k < 4; k++) strobe(w[k], k == 0, 0);
      w = 8'h12;
      strobe(w[0], 1'b1, 0);
      after();
      check("early_err", err, 1);
      check("early_locked", locked, 0);
      check("early_slot", slot, 1);
      check("early_fv", fv, 0);
      for (int k = 1; k < 8; k++) strobe(w[k], 1'b0, 0);
      after();
      check("reacq_no_fv", fv, 0);
      check("reacq_y", y, Clr ? 8'h00 : 8'h22);
      send(8'h34, 1'b1, 0);
      after();
      check("reacq_lock_y", y, 8'h34);
      check("reacq_locked", locked, 1);

      w = 8'hE7;
      for (int k = 0; k < 5; k++) strobe(w[k], k == 0, 0);
      @(negedge clk);
      rst_n = 1'b0; en = 1'b1; din = 1'b1; sync = 1'b0;
      after();
      check("midrst_y", y, 8'h00);
      check("midrst_locked", locked, 0);
      check("midrst_slot", slot, 0);
      set_rst(1'b1);
      strobe(w[6], 1'b0, 0);
      strobe(w[7], 1'b0, 0);
      send(8'h99, 1'b0, 0);
      after();
      check("postrst_slot", slot, 0);
      check("postrst_y", y, 8'h00);

      send(8'h0F, 1'b1, 0);
      strobe(1'b1, 1'b0, 0);
      after();
      check("acq_miss_err", err, 1);
      check("acq_miss_slot", slot, 0);

      send(8'h5A, 1'b1, 0);
      send(8'hC3, 1'b1, 0);
      after();
      check("c3_y", y, 8'hC3);
      send(8'hC3, 1'b0, 0);
      after();
      check("c3_fly_locked", locked, 1);
      strobe(1'b0, 1'b0, 0);
      after();
      check("loss_err", err, 1);
      check("loss_fv", fv, 0);
      check("loss_y", y, Clr ? 8'h00 : 8'hC3);

      repeat (2) tick(1'b0, 1'b0, 1'b0);
      after();
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tdm_demux_1x8.md
Name: tdm_demux_1x8

Overview:
- Time-division 1-to-8 demultiplexer and deserializer; the receive end of an 8-channel TDM link.
- The transmit side is a counter-driven 8:1 select (slot 0..7 on S2..S0) that emits one bit per slot strobe, with SYNC marking slot 0.
- This block locks to the frame marker and rebuilds the 8 channel bits as a registered parallel word.
- Publishes one word per complete good frame; sits between the serial link and downstream channel logic.

Parameters:
ACQ_FRAMES, 2, consecutive good frames (SYNC at slot 0) required in ACQUIRE before entering LOCKED; legal 1..15
MISS_LIMIT, 2, consecutive missing SYNCs at slot 0 tolerated in LOCKED before dropping to HUNT; legal 1..15

Ports:
CLK  input  1  single clock, rising edge
RST_N  input  1  synchronous active-low reset
EN  input  1  slot strobe; DIN/SYNC sampled only when EN=1
DIN  input  1  serial channel bit for current slot
SYNC  input  1  frame marker, valid with slot-0 bit
Y  output  8  last published frame, Y[k] = channel k
FRAME_VALID  output  1  one-cycle pulse, Y just updated
LOCKED  output  1  state==LOCKED
SYNC_ERR  output  1  one-cycle pulse on framing fault
SLOT  output  3  slot index expected on next EN; 0 in HUNT

Behaviour:
- Reset (RST_N=0 at a CLK edge): state HUNT, slot=0, counters=0, buffer=0, Y=0, FRAME_VALID=0, LOCKED=0, SYNC_ERR=0. Reset mid-frame discards the partial frame.
- EN=0: no state change; DIN and SYNC are ignored; pulse outputs return to 0.
- States: HUNT, ACQUIRE, LOCKED.
- HUNT:
  - EN&SYNC: buf[0]=DIN, slot=1, good=0, state=ACQUIRE.
  - EN&!SYNC: bit dropped.
- ACQUIRE/LOCKED, per EN:
  - buf[slot]=DIN, slot increments and wraps 7->0.
- SYNC with slot!=0 (early marker):
  - SYNC_ERR pulse; partial frame discarded.
  - buf[0]=DIN, slot=1, state=ACQUIRE, good=0, miss=0.
  - Applies in LOCKED too.
- slot==0 with SYNC=0:
  - ACQUIRE: SYNC_ERR pulse; go HUNT, bit dropped.
  - LOCKED: miss+1. If miss reaches MISS_LIMIT: SYNC_ERR pulse, go HUNT, bit dropped. Otherwise flywheel: accept the bit as slot 0 and continue.
- slot==0 with SYNC=1: miss=0.
- Slot-7 sample (frame complete):
  - ACQUIRE: good+1. If good reaches ACQ_FRAMES, go LOCKED and publish this frame.
  - LOCKED: publish every frame, including flywheel frames.
- Publish: Y <= {DIN, buf[6:1], buf[0]} registered on the slot-7 EN edge. FRAME_VALID is high the following cycle for exactly one cycle. Latency is 1 clock from the slot-7 strobe to Y/FRAME_VALID.
- Y holds its value between publishes and across HUNT/ACQUIRE (unless the optional feature below is enabled).
- LOCKED and SLOT are registered and reflect the post-edge state.
- Simultaneous events:
  - Early SYNC at slot 7: handled as an early marker (restart), no publish.
  - SYNC_ERR and FRAME_VALID are never high in the same cycle.

Optional Feature:
- Macro: TDM_DEMUX_CLR_ON_LOSS_EN
- Defined: on any transition LOCKED->HUNT or LOCKED->ACQUIRE, Y clears to 8'h00 on the same edge as the transition. FRAME_VALID is not pulsed for the clear.
- Undefined: Y retains the last published frame until the next publish.

Test Plan:
- Reset, then ACQ_FRAMES=2, frames 8'hA5, 8'h3C, 8'hF0 sent back-to-back with SYNC at slot 0 and EN every cycle -> no FRAME_VALID for frame 1; Y=8'h3C with FRAME_VALID 1 cycle after the slot-7 strobe of frame 2, LOCKED=1; then Y=8'hF0.
- Locked, EN asserted every 3rd cycle with frame 8'h81 -> Y=8'h81 one cycle after the slot-7 strobe; SLOT advances only on EN.
- Locked, MISS_LIMIT=2, one frame 8'h55 sent without SYNC -> Y=8'h55 published, LOCKED stays 1. Second consecutive missing SYNC -> SYNC_ERR pulse at slot 0, LOCKED=0, SLOT=0, Y holds 8'h55.
- Locked, SYNC asserted at slot 4 -> SYNC_ERR pulse, LOCKED=0, SLOT=1, no publish; two further good frames 8'h12, 8'h34 -> relocks, Y=8'h34.
- RST_N=0 for one cycle during slot 5 of a locked frame -> Y=0, LOCKED=0, SLOT=0 next cycle; the subsequent frame is ignored until SYNC.
- TDM_DEMUX_CLR_ON_LOSS_EN defined, Y=8'hC3, loss of lock triggered by missed SYNCs -> Y=8'h00 on the transition edge, FRAME_VALID=0.
